// File: rtl/fpu_add_scheduler.sv
// Round-robin arbiter that time-shares one external combinational FP adder among NUM_REQ requesters.
// Optional build macro FPU_ZERO_BYPASS_EN answers ops with a zero operand directly, skipping the adder.
module fpu_add_scheduler #(
   parameter int WORD_LENGTH = 32,
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int FPU_LAT     = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*WORD_LENGTH-1:0] req_a,
   input  logic [NUM_REQ*WORD_LENGTH-1:0] req_b,
   output logic [WORD_LENGTH-1:0]         fpu_a,
   output logic [WORD_LENGTH-1:0]         fpu_b,
   input  logic [WORD_LENGTH-1:0]         fpu_result,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [ID_W-1:0]                rsp_id,
   output logic [WORD_LENGTH-1:0]         rsp_data,
   output logic                           busy
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits for ready, and payload stays stable while valid is high without ready.
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                 state, state_nxt;
   logic [ID_W-1:0]        rr_ptr;
   logic [ID_W-1:0]        gnt_idx;
   logic                   gnt_found;
   logic [3:0]             lat_cnt;
   logic [WORD_LENGTH-1:0] gnt_a, gnt_b;
   logic                   byp_take;
   logic [WORD_LENGTH-1:0] byp_data;

   // Search starts one past the last served requester so priority rotates.
   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'(idx);
         end
      end
   end

   assign gnt_a = req_a[gnt_idx*WORD_LENGTH +: WORD_LENGTH];
   assign gnt_b = req_b[gnt_idx*WORD_LENGTH +: WORD_LENGTH];

`ifdef FPU_ZERO_BYPASS_EN
   // The adder forces the hidden bit, so any zero operand must be resolved here.
   logic a_zero, b_zero;
   assign a_zero   = (gnt_a[WORD_LENGTH-2:0] == '0);
   assign b_zero   = (gnt_b[WORD_LENGTH-2:0] == '0);
   assign byp_take = a_zero | b_zero;
   always_comb begin
      byp_data = gnt_a;
      if (a_zero && b_zero)
         byp_data = {gnt_a[WORD_LENGTH-1] & gnt_b[WORD_LENGTH-1], {(WORD_LENGTH-1){1'b0}}};
      else if (a_zero)
         byp_data = gnt_b;
   end
`else
   assign byp_take = 1'b0;
   assign byp_data = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (gnt_found) begin
               req_ready[gnt_idx] = 1'b1;
               state_nxt          = byp_take ? RESP : WAIT;
            end
         end
         WAIT:    if (lat_cnt == 4'd1) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpu_a     <= '0;
         fpu_b     <= '0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         rsp_valid <= 1'b0;
         lat_cnt   <= '0;
         rr_ptr    <= ID_W'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (gnt_found) begin
                  rsp_id <= gnt_idx;
                  rr_ptr <= gnt_idx;
                  if (byp_take) begin
                     rsp_data  <= byp_data;
                     rsp_valid <= 1'b1;
                  end else begin
                     fpu_a   <= gnt_a;
                     fpu_b   <= gnt_b;
                     lat_cnt <= 4'(FPU_LAT);
                  end
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt - 4'd1;
               if (lat_cnt == 4'd1) begin
                  rsp_data  <= fpu_result;
                  rsp_valid <= 1'b1;
               end
            end
            RESP:    if (rsp_ready) rsp_valid <= 1'b0;
            default: rsp_valid <= 1'b0;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/fpu_add_scheduler.md
Name: fpu_add_scheduler

Overview:
- Round-robin scheduler that shares one combinational single-precision FP adder among NUM_REQ requesters.
- Accepts one operand pair per grant and drives registered operands onto the shared adder.
- Waits FPU_LAT cycles for the adder to settle, then returns the sum with the requester's id over a valid/ready response channel.
- Sits between requesting datapath units and the shared adder instance; the adder itself is external.

Parameters:
- WORD_LENGTH, 32, operand/result width (IEEE-754 single).
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of rsp_id; must equal ceil(log2(NUM_REQ)).
- FPU_LAT, 1, cycles fpu_a/fpu_b are held before fpu_result is sampled (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept pulse.
- req_a  in  NUM_REQ*WORD_LENGTH  operand A, requester i at [i*WORD_LENGTH +: WORD_LENGTH].
- req_b  in  NUM_REQ*WORD_LENGTH  operand B, same packing.
- fpu_a  out  WORD_LENGTH  registered operand A to the shared adder.
- fpu_b  out  WORD_LENGTH  registered operand B to the shared adder.
- fpu_result  in  WORD_LENGTH  shared adder sum.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester served.
- rsp_data  out  WORD_LENGTH  sum.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; fpu_a, fpu_b, rsp_data = 0; rsp_id = 0; rsp_valid = 0; req_ready = 0; busy = 0; lat_cnt = 0; rr_ptr = NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-operation discards the in-flight op; no response is produced.
- States:
  - IDLE: if any req_valid, grant g = first set bit searching from rr_ptr+1 with modulo-NUM_REQ wrap. req_ready[g] = 1 combinationally in that cycle only. At the clock edge: fpu_a<=req_a[g], fpu_b<=req_b[g], rsp_id<=g, rr_ptr<=g, lat_cnt<=FPU_LAT, go to WAIT. With no req_valid, stay in IDLE with all req_ready = 0.
  - WAIT: lat_cnt decrements each cycle. In the cycle where lat_cnt==1: rsp_data<=fpu_result, rsp_valid<=1, go to RESP.
  - RESP: rsp_valid, rsp_id and rsp_data are held stable. When rsp_ready==1: rsp_valid<=0, go to IDLE.
- req_ready is 0 in WAIT and RESP.
- Latency: grant in cycle T → rsp_valid first high in cycle T+FPU_LAT+1. Earliest next grant is the cycle after the response handshake.
- Requester rule: req_valid and operands must be held stable until req_ready. Requesters must not gate req_valid on req_ready.
- fpu_a/fpu_b hold their value from the last grant until the next grant.
- Fairness: a requester that stays valid is served within NUM_REQ grants.
- The scheduler never inspects or modifies the adder's arithmetic; the result is passed through bit-exact.

Optional Feature:
- Macro: FPU_ZERO_BYPASS_EN.
- Enabled: at grant, if req_a[g][30:0]==0 or req_b[g][30:0]==0, skip the adder:
  - rsp_data<= the other operand;
  - if both are zero, rsp_data<={a[31]&b[31], 31'b0};
  - go directly IDLE→RESP, with rsp_valid high in cycle T+1;
  - fpu_a/fpu_b are not updated.
  - Purpose: the shared adder forces the hidden bit and cannot normalise a zero result.
- Disabled: every op goes through WAIT.

Test Plan:
- FPU_LAT=1, req_valid=4'b0001, A=0x3F800000, B=0x40000000, adder model returns 0x40400000 → req_ready[0] high in cycle T only; rsp_valid in T+2 with rsp_data=0x40400000, rsp_id=0.
- All four req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0; rsp_id sequence matches; no requester is skipped.
- rsp_ready held 0 for 5 cycles during RESP → rsp_valid/rsp_data/rsp_id stable; all req_ready=0; busy=1. Release → IDLE next cycle.
- FPU_LAT=3, single request granted in T → fpu_a/fpu_b stable T+1..T+3; rsp_valid first high in T+4; rsp_data equals the model sum of the held operands.
- rst pulsed during WAIT → all outputs 0 immediately; next request from requester 2 is granted before requester 3 (rr_ptr=3 restored).
- With FPU_ZERO_BYPASS_EN: A=0x00000000, B=0x40A00000 → rsp_valid in T+1 with rsp_data=0x40A00000; fpu_a/fpu_b unchanged. A=0x80000000, B=0x80000000 → rsp_data=0x80000000. Without the macro, the same stimulus passes through WAIT.
